mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Memory access controller between the ARM datapath load/store unit and the byte-addressed 512-byte data RAM. It accepts one load/store request at a time and checks size and alignment. It then runs the RAM enable/readWrite/done handshake and returns lane-steered, zero- or sign-extended load data with a one-cycle ready pulse. All sequencing is registered, so the datapath sees a clean synchronous interface regardless of RAM access time.

Parameters:
ADDR_W, 9, byte address width (512-byte RAM).
TIMEOUT_CYCLES, 64, cycles allowed for ram_done before the access is aborted with a fault.
CNT_W, 7, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
mem_req  in  1  request valid; sampled only in IDLE.
mem_rw  in  1  1 = read (load), 0 = write (store).
mem_size  in  2  MAS encoding: 00 byte, 01 halfword, 10 word, 11 illegal.
mem_signed  in  1  sign-extend byte/halfword loads.
mem_addr  in  ADDR_W  byte address.
mem_wdata  in  32  store data, right-justified.
mem_rdata  out  32  load result; valid when mem_ready=1.
mem_ready  out  1  one-cycle completion pulse.
mem_fault  out  1  qualifies mem_ready: access aborted (illegal size, misaligned, timeout).
mem_busy  out  1  high in every state except IDLE.
ram_enable  out  1  RAM enable.
ram_rw  out  1  RAM readWrite (1 read, 0 write).
ram_address  out  ADDR_W  word-aligned base, {addr[ADDR_W-1:2],2'b00}.
ram_A  out  2  byte offset addr[1:0].
ram_MAS  out  2  access size to RAM.
ram_dataIn  out  32  store data to RAM.
ram_dataOut  in  32  RAM read data (byte in [7:0], half in [15:0], word in [31:0], upper bits zero).
ram_done  in  1  RAM completion flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; mem_rdata=0, mem_ready=0, mem_fault=0, mem_busy=0, ram_enable=0, ram_rw=1, ram_address=0, ram_A=0, ram_MAS=0, ram_dataIn=0, timeout counter=0. Reset mid-access drops ram_enable on the next edge, and no ready pulse is issued for the aborted access.
- All outputs are registered.
- FSM states: IDLE, CHECK, ACK, WAIT, RESP.
- IDLE: mem_req=1 latches rw, size, signed, addr and wdata, then moves to CHECK. mem_req outside IDLE is ignored; requests are not queued.
- CHECK (1 cycle): fault if size=11, or size=01 and addr[0]=1, or size=10 and addr[1:0]!=00. On fault go to RESP with the fault flag set and issue no RAM access. Otherwise drive the RAM ports and assert ram_enable, then go to ACK.
- Store data steering: byte in ram_dataIn[7:0], half in [15:0], word in [31:0]; unused bits are 0.
- ACK: hold ram_enable; wait for ram_done=0, which discards a stale done from the previous access, then go to WAIT.
- WAIT: hold ram_enable and wait for ram_done=1. On done, capture ram_dataOut, deassert ram_enable and go to RESP.
- Timeout: the counter runs in ACK+WAIT and clears on entry to ACK. When it reaches TIMEOUT_CYCLES-1, deassert ram_enable and go to RESP with the fault flag set.
- RESP (1 cycle): mem_ready=1 and mem_fault=flag.
  - Good loads: byte gives {24{s&d[7]},d[7:0]}, half gives {16{s&d[15]},d[15:0]}, word gives d.
  - Stores and faults leave mem_rdata at 0.
  - Next state is IDLE.
- Minimum latency from mem_req to mem_ready is 4 cycles (IDLE→CHECK→ACK→WAIT→RESP) when the RAM drops done and raises it one cycle later each.
- mem_req held high across RESP starts a new access from IDLE on the following cycle.

Optional Feature:
ROTATE_UNALIGNED_EN
- Defined: a misaligned word load is not faulted. It is issued as an aligned word read (ram_A=00), and the result is rotated right by 8*addr[1:0], matching ARM LDR semantics. Misaligned word stores still fault.
- Undefined: every misaligned word access faults in CHECK.

Test Plan:
- Word load, addr 0x004, RAM returns 0xDEADBEEF after done drops and rises → mem_ready pulse, mem_rdata=0xDEADBEEF, mem_fault=0, ram_MAS=10, ram_address=0x004.
- Signed byte load, addr 0x013, RAM returns 0x00000080 → mem_rdata=0xFFFFFF80; the same load unsigned → 0x00000080; ram_A=11.
- Halfword store, addr 0x021, wdata 0x1234ABCD → fault pulse in RESP, ram_enable never asserted; addr 0x022 → ram_dataIn=0x0000ABCD, ram_rw=0.
- RAM holds ram_done stuck high and never drops it → after TIMEOUT_CYCLES cycles mem_ready=1 with mem_fault=1, and ram_enable=0.
- Reset asserted in WAIT → next edge: ram_enable=0, mem_busy=0, no mem_ready; a new request afterwards completes normally.
- With ROTATE_UNALIGNED_EN, word load addr 0x005, RAM returns 0x11223344 → mem_rdata=0x44112233, mem_fault=0; without the macro → mem_fault=1.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: LSU-to-RAM access sequencer with size/alignment checks; define ROTATE_UNALIGNED_EN for ARM-style rotated misaligned word loads.
module mem_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_fault,
  output logic              mem_busy,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_address,
  output logic [1:0]        ram_A,
  output logic [1:0]        ram_MAS,
  output logic [31:0]       ram_dataIn,
  input  logic [31:0]       ram_dataOut,
  input  logic              ram_done
);
`ifdef ROTATE_UNALIGNED_EN
  localparam logic ROT = 1'b1;
`else
  localparam logic ROT = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CHECK, ACK, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic rw_q, rw_d, sgn_q, sgn_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d, din_q, din_d;
  logic ready_q, ready_d, fault_q, fault_d, busy_q, busy_d, en_q, en_d, ramrw_q, ramrw_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [1:0] ra_q, ra_d, mas_q, mas_d;
  logic bad, tmo;
  logic [4:0] sh;
  logic [31:0] d, wd, ld, sdata;
  assign bad = (size_q == 2'b11) | (size_q == 2'b01 & addr_q[0])
             | (size_q == 2'b10 & |addr_q[1:0] & ~(ROT & rw_q));
  assign tmo = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign d = ram_dataOut;
  assign sh = {addr_q[1:0], 3'b000};
  // Misaligned word reads come back aligned; rotate right by the byte offset.
  assign wd = ROT ? ((d >> sh) | (d << (6'd32 - {1'b0, sh}))) : d;
  assign ld = size_q == 2'b00 ? {{24{sgn_q & d[7]}}, d[7:0]}
            : size_q == 2'b01 ? {{16{sgn_q & d[15]}}, d[15:0]} : wd;
  assign sdata = size_q == 2'b00 ? {24'd0, wdata_q[7:0]}
               : size_q == 2'b01 ? {16'd0, wdata_q[15:0]} : wdata_q;
  always_comb begin
    state_d = state_q;
    rw_d = rw_q;
    sgn_d = sgn_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    rdata_d = 32'd0;
    fault_d = 1'b0;
    ramrw_d = ramrw_q;
    raddr_d = raddr_q;
    ra_d = ra_q;
    mas_d = mas_q;
    din_d = din_q;
    case (state_q)
      IDLE: if (mem_req) begin
        state_d = CHECK;
        rw_d = mem_rw;
        sgn_d = mem_signed;
        size_d = mem_size;
        addr_d = mem_addr;
        wdata_d = mem_wdata;
      end
      CHECK: if (bad) begin
        state_d = RESP;
        fault_d = 1'b1;
      end else begin
        state_d = ACK;
        cnt_d = '0;
        ramrw_d = rw_q;
        raddr_d = {addr_q[ADDR_W-1:2], 2'b00};
        ra_d = (ROT && size_q == 2'b10) ? 2'b00 : addr_q[1:0];
        mas_d = size_q;
        din_d = sdata;
      end
      ACK: begin
        cnt_d = cnt_q + 1'b1;
        state_d = tmo ? RESP : ram_done ? ACK : WAIT;
        fault_d = tmo;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (ram_done | tmo) ? RESP : WAIT;
        fault_d = ~ram_done & tmo;
        rdata_d = (ram_done & rw_q) ? ld : 32'd0;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == RESP;
    en_d = state_d == ACK || state_d == WAIT;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q <= 1'b0;
      sgn_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= 32'd0;
      cnt_q <= '0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q <= 1'b0;
      en_q <= 1'b0;
      ramrw_q <= 1'b1;
      raddr_q <= '0;
      ra_q <= 2'b00;
      mas_q <= 2'b00;
      din_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      sgn_q <= sgn_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      busy_q <= busy_d;
      en_q <= en_d;
      ramrw_q <= ramrw_d;
      raddr_q <= raddr_d;
      ra_q <= ra_d;
      mas_q <= mas_d;
      din_q <= din_d;
    end
  end
  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_fault = fault_q;
  assign mem_busy = busy_q;
  assign ram_enable = en_q;
  assign ram_rw = ramrw_q;
  assign ram_address = raddr_q;
  assign ram_A = ra_q;
  assign ram_MAS = mas_q;
  assign ram_dataIn = din_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed plus random accesses against a behavioural RAM and result model.
module tb_mem_access_ctrl;
`ifdef ROTATE_UNALIGNED_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  localparam int TMO = 64;
  logic clk = 1'b0, reset = 1'b1;
  logic mem_req = 1'b0, mem_rw = 1'b0, mem_signed = 1'b0;
  logic [1:0] mem_size = 2'b00;
  logic [8:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0, ram_dataOut = '0;
  logic ram_done = 1'b0;
  logic [31:0] mem_rdata, ram_dataIn;
  logic mem_ready, mem_fault, mem_busy, ram_enable, ram_rw;
  logic [8:0] ram_address;
  logic [1:0] ram_A, ram_MAS;
  int pass_n = 0, total_n = 0;
  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_fault(mem_fault), .mem_busy(mem_busy), .ram_enable(ram_enable),
    .ram_rw(ram_rw), .ram_address(ram_address), .ram_A(ram_A), .ram_MAS(ram_MAS),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut), .ram_done(ram_done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic access(input logic rw, input logic [1:0] sz, input logic sg, input logic [8:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input bit stuck, input string tag);
    logic [31:0] mask, v, exp_d;
    bit exp_f, seen;
    int n, nb;
    nb = 1 << sz;
    mask = sz == 2'd0 ? 32'hFF : sz == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
    exp_f = sz == 2'd3 || ((a % nb) != 0 && !(ROT && sz == 2'd2 && rw)) || stuck;
    v = rd & mask;
    if (sz == 2'd2) begin
      for (int i = 0; i < 4; i++) exp_d[8*i +: 8] = v[8*((i + a % 4) % 4) +: 8];
    end else exp_d = (sg && (v & ((mask >> 1) + 1)) != 0) ? (v | ~mask) : v;
    if (exp_f || !rw) exp_d = 32'd0;
    mem_req = 1'b1; mem_rw = rw; mem_size = sz; mem_signed = sg; mem_addr = a; mem_wdata = wd;
    ram_done = 1'b1;
    step();
    mem_req = 1'b0;
    n = 1;
    seen = 0;
    while (!mem_ready && n < 200) begin
      if (ram_enable) begin
        if (!seen) begin
          chk({tag, "_addr"}, ram_address, a - a % 4);
          chk({tag, "_A"}, ram_A, (ROT && sz == 2'd2) ? 0 : a % 4);
          chk({tag, "_mas"}, ram_MAS, sz);
          chk({tag, "_rw"}, ram_rw, rw);
          if (!rw) chk({tag, "_din"}, ram_dataIn, wd & mask);
          seen = 1;
          if (!stuck) ram_done = 1'b0;
        end else if (!stuck) begin
          ram_done = 1'b1;
          ram_dataOut = v;
        end
      end
      step();
      n++;
    end
    chk({tag, "_ready"}, mem_ready, 1);
    chk({tag, "_fault"}, mem_fault, exp_f);
    chk({tag, "_rdata"}, mem_rdata, exp_d);
    chk({tag, "_ram_used"}, seen, !(exp_f && !stuck));
    chk({tag, "_en_off"}, ram_enable, 0);
    if (stuck) chk({tag, "_lat"}, n, TMO + 2);
    else if (!exp_f) chk({tag, "_lat"}, n, 4);
    step();
    chk({tag, "_pulse"}, mem_ready, 0);
    chk({tag, "_idle"}, mem_busy, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_ready", mem_ready, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_en", ram_enable, 0);
    chk("rst_rw", ram_rw, 1);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_din", ram_dataIn, 0);
    reset = 1'b0;
    step();
    access(1'b1, 2'd2, 1'b0, 9'h004, 32'h0, 32'hDEADBEEF, 0, "ldw");
    access(1'b1, 2'd0, 1'b1, 9'h013, 32'h0, 32'h00000080, 0, "ldsb");
    access(1'b1, 2'd0, 1'b0, 9'h013, 32'h0, 32'h00000080, 0, "ldub");
    access(1'b1, 2'd1, 1'b1, 9'h0A2, 32'h0, 32'h0000_9001, 0, "ldsh");
    access(1'b0, 2'd1, 1'b0, 9'h021, 32'h1234ABCD, 32'h0, 0, "sth_mis");
    access(1'b0, 2'd1, 1'b0, 9'h022, 32'h1234ABCD, 32'h0, 0, "sth");
    access(1'b0, 2'd0, 1'b0, 9'h1FF, 32'hCAFEF00D, 32'h0, 0, "stb");
    access(1'b1, 2'd3, 1'b0, 9'h000, 32'h0, 32'h0, 0, "ill");
    access(1'b1, 2'd2, 1'b0, 9'h005, 32'h0, 32'h11223344, 0, "ldw_mis");
    access(1'b0, 2'd2, 1'b0, 9'h006, 32'h55667788, 32'h0, 0, "stw_mis");
    access(1'b1, 2'd2, 1'b0, 9'h040, 32'h0, 32'h0, 1, "tmo");
    mem_req = 1'b1; mem_rw = 1'b1; mem_size = 2'd2; mem_addr = 9'h008;
    step();
    mem_req = 1'b0;
    step();
    chk("rstw_ack_en", ram_enable, 1);
    ram_done = 1'b0;
    step();
    chk("rstw_wait_en", ram_enable, 1);
    reset = 1'b1;
    step();
    chk("rstw_en", ram_enable, 0);
    chk("rstw_busy", mem_busy, 0);
    chk("rstw_ready", mem_ready, 0);
    reset = 1'b0;
    ram_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstw_noready", mem_ready, 0);
    end
    access(1'b1, 2'd2, 1'b0, 9'h00C, 32'h0, 32'h0BADCAFE, 0, "post_rst");
    for (int i = 0; i < 40; i++)
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             9'($urandom), $urandom, $urandom, 0, "rand");
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
